// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan controller, the 8:1 select mux and the downstream sample consumer.
// Optional out_par wire is present when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_ctrl_if #(
  parameter int SEL_W  = 3,
  parameter int DATA_W = 4
);
  logic [(1<<SEL_W)-1:0] req;
  logic [SEL_W-1:0]      sel;
  logic [DATA_W-1:0]     mux_o;
  logic [DATA_W-1:0]     out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
`ifdef MUX_SCAN_PARITY_EN
  logic                  out_par;
`endif

  modport master (
    input  req, mux_o, out_ready,
`ifdef MUX_SCAN_PARITY_EN
    output out_par,
`endif
    output sel, out_data, out_ch, out_valid, busy
  );

  modport slave (
    output req, mux_o, out_ready,
`ifdef MUX_SCAN_PARITY_EN
    input  out_par,
`endif
    input  sel, out_data, out_ch, out_valid, busy
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan controller: grants a requesting channel, drives the mux select, waits
// SETTLE_CYC cycles, captures the mux output and offers it over valid/ready.
// Optional feature macro: MUX_SCAN_PARITY_EN adds registered out_par = ^out_data.
module mux_scan_ctrl #(
  parameter int SEL_W      = 3,
  parameter int DATA_W     = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_scan_ctrl_if.master  bus
);
  localparam int NCH   = 1 << SEL_W;
  localparam int CNT_W = 4;

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE_CYC=%0d outside 1..15", SETTLE_CYC);
  end

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t             state, state_n;
  logic [SEL_W-1:0]   sel_q, sel_n;
  logic [SEL_W-1:0]   last_ch, last_n;
  logic [SEL_W-1:0]   ch_q, ch_n;
  logic [DATA_W-1:0]  data_q, data_n;
  logic               valid_q, valid_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [SEL_W-1:0]   grant;
  logic               found;
`ifdef MUX_SCAN_PARITY_EN
  logic               par_q, par_n;
`endif

  // Search starts one past the last captured channel; the SEL_W-bit sum wraps NCH-1 -> 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      if (!found && bus.req[last_ch + SEL_W'(i)]) begin
        grant = last_ch + SEL_W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    last_n  = last_ch;
    ch_n    = ch_q;
    data_n  = data_q;
    valid_n = valid_q;
    cnt_n   = cnt;
`ifdef MUX_SCAN_PARITY_EN
    par_n   = par_q;
`endif
    case (state)
      IDLE: begin
        if (|bus.req) begin
          sel_n   = grant;
          cnt_n   = CNT_W'(SETTLE_CYC - 1);
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          data_n  = bus.mux_o;
          ch_n    = sel_q;
          last_n  = sel_q;
          valid_n = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
          par_n   = ^bus.mux_o;
`endif
          state_n = HOLD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_q   <= '0;
      last_ch <= SEL_W'(NCH - 1);
      ch_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt     <= '0;
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      sel_q   <= sel_n;
      last_ch <= last_n;
      ch_q    <= ch_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      cnt     <= cnt_n;
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state != IDLE);
`ifdef MUX_SCAN_PARITY_EN
  assign bus.out_par   = par_q;
`endif
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: behavioural 8:1 mux table, expected samples queued at
// stimulus time and popped when out_valid appears.
module tb_mux_scan_ctrl;
  logic clk;
  logic rst_n;
  logic [7:0][3:0] tbl;
  int total;
  int passed;
  int fails;

  typedef struct {
    logic [2:0] ch;
    logic [3:0] data;
  } exp_t;
  exp_t exp_q[$];

  mux_scan_ctrl_if #(.SEL_W(3), .DATA_W(4)) bus ();

  assign bus.mux_o = tbl[bus.sel];

  mux_scan_ctrl #(.SEL_W(3), .DATA_W(4), .SETTLE_CYC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] ch);
    exp_t e;
    e.ch   = ch;
    e.data = tbl[ch];
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_qnonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_ch"},    32'(bus.out_ch),    32'(e.ch));
      check({tag, "_data"},  32'(bus.out_data),  32'(e.data));
`ifdef MUX_SCAN_PARITY_EN
      check({tag, "_par"},   32'(bus.out_par),   32'(^e.data));
`endif
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 20 && !bus.out_valid; n++) step();
    check({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [12:0] snap;
    total = 0; passed = 0; fails = 0;
    rst_n = 1'b1;
    bus.req = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) tbl[i] = 4'(i) ^ 4'h5;

    // async reset takes effect before the first clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst_sel",   32'(bus.sel),       32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_data",  32'(bus.out_data),  32'd0);
    check("rst_ch",    32'(bus.out_ch),    32'd0);
    step();
    rst_n = 1'b1;

    // single request, latency
    tbl[2] = 4'hA;
    bus.req = 8'h04;
    bus.out_ready = 1'b1;
    push_exp(3'd2);
    step();
    check("t2_sel",   32'(bus.sel),       32'd2);
    check("t2_busy",  32'(bus.busy),      32'd1);
    check("t2_novld", 32'(bus.out_valid), 32'd0);
    step();
    pop_check("t2");
    bus.req = '0;
    step();
    check("t2_drop", 32'(bus.out_valid), 32'd0);
    check("t2_idle", 32'(bus.busy),      32'd0);

    // all requests: 0..7,0 one capture per 3 cycles
    do_reset();
    for (int i = 0; i < 8; i++) tbl[i] = 4'(i * 3 + 1);
    bus.req = 8'hFF;
    for (int i = 0; i < 9; i++) push_exp(3'(i));
    wait_valid("t3_first");
    pop_check("t3_0");
    for (int k = 1; k < 9; k++) begin
      step();
      check("t3_gap", 32'(bus.out_valid), 32'd0);
      step();
      step();
      check("t3_cadence", 32'(bus.out_valid), 32'd1);
      pop_check("t3_rr");
    end
    bus.req = '0;
    step();

    // wrap: last_ch=7 with req 0 and 7
    do_reset();
    bus.req = 8'h81;
    push_exp(3'd0);
    push_exp(3'd7);
    push_exp(3'd0);
    for (int k = 0; k < 3; k++) begin
      wait_valid("t4");
      pop_check("t4_wrap");
      if (k == 2) bus.req = '0;
      step();
    end

    // backpressure: outputs frozen while ready low
    tbl[3] = 4'hC;
    bus.req = 8'h08;
    bus.out_ready = 1'b0;
    push_exp(3'd3);
    wait_valid("t5");
    pop_check("t5");
    snap = {bus.out_valid, bus.out_data, bus.out_ch, bus.sel, 2'b00};
    tbl[3] = 4'h1;
    bus.req = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t5_hold", 32'({bus.out_valid, bus.out_data, bus.out_ch, bus.sel, 2'b00}), 32'(snap));
    end
    bus.out_ready = 1'b1;
    step();
    check("t5_release", 32'(bus.out_valid), 32'd0);

    // req drops during SETTLE: sample still taken from granted channel
    tbl[1] = 4'h7;
    bus.req = 8'h02;
    push_exp(3'd1);
    step();
    check("t6_sel", 32'(bus.sel), 32'd1);
    bus.req = '0;
    step();
    pop_check("t6");
`ifdef MUX_SCAN_PARITY_EN
    check("t6_par7", 32'(bus.out_par), 32'd1);
`endif
    step();
    check("t6_done", 32'(bus.out_valid), 32'd0);

    // reset mid-HOLD: drops at once, no clock edge needed
    tbl[4] = 4'h5;
    bus.req = 8'h10;
    bus.out_ready = 1'b0;
    push_exp(3'd4);
    wait_valid("t1");
    pop_check("t1");
    bus.req = '0;
    rst_n = 1'b0;
    #1;
    check("t1_valid", 32'(bus.out_valid), 32'd0);
    check("t1_sel",   32'(bus.sel),       32'd0);
    check("t1_busy",  32'(bus.busy),      32'd0);
    check("t1_data",  32'(bus.out_data),  32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("t1_norecover", 32'(bus.out_valid), 32'd0);
    check("q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
